mem_port_arbiter: RTL and testbench

// - Shares one unified 32-bit instruction/data memory between two requesters:

---
 rtl/mem_port_arbiter_if.sv | 49 ++++
 rtl/mem_port_arbiter.sv | 156 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: core port C, loader port L and memory-macro signals
// of the unified instruction/data memory arbiter.
// slave  = arbiter side, master = requesters plus memory side.
interface mem_port_arbiter_if #(
    parameter int unsigned ADDR_W = 32
);
    // core port
    logic              c_req;
    logic              c_we;
    logic [2:0]        c_funct3;
    logic [ADDR_W-1:0] c_addr;
    logic [31:0]       c_wdata;
    logic              c_done;
    logic              c_err;
    logic [31:0]       c_rdata;
    // loader port
    logic              l_req;
    logic              l_we;
    logic [ADDR_W-1:0] l_addr;
    logic [31:0]       l_wdata;
    logic              l_done;
    logic [31:0]       l_rdata;
    // status and memory side
    logic              busy;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [3:0]        mem_be;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;

    modport slave (
        input  c_req, c_we, c_funct3, c_addr, c_wdata,
        output c_done, c_err, c_rdata,
        input  l_req, l_we, l_addr, l_wdata,
        output l_done, l_rdata,
        output busy, mem_en, mem_we, mem_addr, mem_be, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output c_req, c_we, c_funct3, c_addr, c_wdata,
        input  c_done, c_err, c_rdata,
        output l_req, l_we, l_addr, l_wdata,
        input  l_done, l_rdata,
        input  busy, mem_en, mem_we, mem_addr, mem_be, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one 32-bit memory between the core (C) and the
// program loader (L). Round-robin grant, one mem_en per access, fixed read
// latency, byte-lane steering for stores and load extension.
// Optional: define MEM_ARB_MISALIGN_CHECK_EN to reject misaligned half/word
// accesses instead of truncating their low address bits.
module mem_port_arbiter #(
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned READ_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    mem_port_arbiter_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

    // WAIT lasts READ_LAT-1 cycles; cnt holds the WAIT cycles left after the current one.
    localparam logic [3:0] CNT_INIT = 4'((READ_LAT > 1) ? READ_LAT - 2 : 0);

    state_t            state, state_nx;
    logic              grant_l, last_l, we_q;
    logic [2:0]        f3_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q, c_rdata_q, l_rdata_q;
    logic [3:0]        cnt, cnt_nx;
    logic              take, pick_l, capture;
    logic              illegal, misalign, skip;
    logic [1:0]        size, off, eff_off;
    logic [3:0]        be_w;
    logic [31:0]       wdata_lane, shifted, load_ext;

    // Decode the latched access: legality, lane offset, enables, store and load data.
    always_comb begin
        size    = grant_l ? 2'b10 : f3_q[1:0];
        off     = addr_q[1:0];
        illegal = !grant_l && (f3_q == 3'b011 || f3_q[2:1] == 2'b11);
`ifdef MEM_ARB_MISALIGN_CHECK_EN
        misalign = (size == 2'b01 && off[0]) || (size == 2'b10 && off != 2'b00);
`else
        misalign = 1'b0;
`endif
        skip       = illegal || misalign;
        eff_off    = off;
        be_w       = 4'b0001 << off;
        wdata_lane = {4{wdata_q[7:0]}};
        case (size)
            2'b01: begin
                eff_off    = {off[1], 1'b0};
                be_w       = off[1] ? 4'b1100 : 4'b0011;
                wdata_lane = {2{wdata_q[15:0]}};
            end
            2'b10: begin
                eff_off    = 2'b00;
                be_w       = 4'b1111;
                wdata_lane = wdata_q;
            end
            default: ;
        endcase
        shifted = bus.mem_rdata >> {eff_off, 3'b000};
        case (f3_q)
            3'b000:  load_ext = {{24{shifted[7]}}, shifted[7:0]};
            3'b001:  load_ext = {{16{shifted[15]}}, shifted[15:0]};
            3'b100:  load_ext = {24'b0, shifted[7:0]};
            3'b101:  load_ext = {16'b0, shifted[15:0]};
            default: load_ext = shifted;
        endcase
    end

    // Next-state logic: grant in IDLE, strobe in ISSUE, count out read latency.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        take     = 1'b0;
        pick_l   = 1'b0;
        capture  = 1'b0;
        case (state)
            S_IDLE: begin
                if (bus.c_req || bus.l_req) begin
                    take     = 1'b1;
                    pick_l   = bus.l_req && (!bus.c_req || !last_l);
                    state_nx = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (skip || we_q) begin
                    state_nx = S_DONE;
                end else if (READ_LAT <= 1) begin
                    capture  = 1'b1;
                    state_nx = S_DONE;
                end else begin
                    cnt_nx   = CNT_INIT;
                    state_nx = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt == 4'd0) begin
                    capture  = 1'b1;
                    state_nx = S_DONE;
                end else begin
                    cnt_nx = cnt - 4'd1;
                end
            end
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // State and latency counter; reset aborts any access in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    // Request latch, read-data capture and round-robin history.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            grant_l   <= 1'b0;
            last_l    <= 1'b1;
            we_q      <= 1'b0;
            f3_q      <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            c_rdata_q <= '0;
            l_rdata_q <= '0;
        end else begin
            if (take) begin
                grant_l <= pick_l;
                we_q    <= pick_l ? bus.l_we    : bus.c_we;
                f3_q    <= pick_l ? 3'b010      : bus.c_funct3;
                addr_q  <= pick_l ? bus.l_addr  : bus.c_addr;
                wdata_q <= pick_l ? bus.l_wdata : bus.c_wdata;
            end
            if (capture) begin
                if (grant_l) l_rdata_q <= bus.mem_rdata;
                else         c_rdata_q <= load_ext;
            end
            if (state == S_DONE) last_l <= grant_l;
        end
    end

    assign bus.busy      = (state != S_IDLE);
    assign bus.mem_en    = (state == S_ISSUE) && !skip;
    assign bus.mem_we    = bus.mem_en && we_q;
    assign bus.mem_be    = !bus.mem_en ? 4'b0000 : (we_q ? be_w : 4'b1111);
    assign bus.mem_addr  = {addr_q[ADDR_W-1:2], 2'b00};
    assign bus.mem_wdata = wdata_lane;
    assign bus.c_done    = (state == S_DONE) && !grant_l;
    assign bus.c_err     = bus.c_done && skip;
    assign bus.c_rdata   = c_rdata_q;
    assign bus.l_done    = (state == S_DONE) && grant_l;
    assign bus.l_rdata   = l_rdata_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: randomized scoreboard bench for mem_port_arbiter
// with READ_LAT=2, a byte-level reference memory and a synchronous RAM model.
module tb_mem_port_arbiter;
    localparam int unsigned ADDR_W   = 32;
    localparam int unsigned READ_LAT = 2;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_W(ADDR_W)) bus ();

    mem_port_arbiter #(.ADDR_W(ADDR_W), .READ_LAT(READ_LAT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // RAM model: data valid the cycle after mem_en, garbage otherwise
    logic [31:0] env_mem [0:255] = '{default: 32'h0};
    logic [31:0] rd_pipe;
    assign bus.mem_rdata = rd_pipe;

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = wd[8*i +: 8];
        return r;
    endfunction

    always @(posedge clk) begin
        if (bus.mem_en && bus.mem_we)
            env_mem[bus.mem_addr[9:2]] <= merge(env_mem[bus.mem_addr[9:2]], bus.mem_wdata, bus.mem_be);
        if (bus.mem_en && !bus.mem_we) rd_pipe <= env_mem[bus.mem_addr[9:2]];
        else                           rd_pipe <= $urandom;
    end

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit          port_l;
        bit          we;
        bit          exp_mem;
        bit          err;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int unsigned lat;
        int unsigned start;
    } item_t;

    item_t       q[$];
    logic [7:0]  ref_mem [0:1023] = '{default: 8'h0};
    int unsigned checks   = 0;
    int unsigned failures = 0;
    int unsigned mem_seen = 0;
    bit          directed = 1'b1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got=%h expected=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: byte-addressed memory, sizes 1/2/4, align-down or reject.
    task automatic push_expect(input bit pl, input bit we, input logic [2:0] f3,
                               input logic [31:0] addr, input logic [31:0] wd);
        item_t       it;
        int unsigned n, ea;
        bit          illegal, mis, sgn;
        logic [31:0] v;
        illegal = 1'b0; sgn = 1'b0; n = 4;
        if (!pl) begin
            case (f3)
                3'b000:  begin n = 1; sgn = 1'b1; end
                3'b001:  begin n = 2; sgn = 1'b1; end
                3'b010:  n = 4;
                3'b100:  n = 1;
                3'b101:  n = 2;
                default: illegal = 1'b1;
            endcase
        end
        mis = 1'b0;
`ifdef MEM_ARB_MISALIGN_CHECK_EN
        mis = (addr % n) != 0;
`endif
        ea         = addr - (addr % n);
        it.port_l  = pl;
        it.we      = we;
        it.exp_mem = !(illegal || mis);
        it.err     = !pl && (illegal || mis);
        it.addr    = ea & 32'hFFFF_FFFC;
        it.be      = '0;
        it.wdata   = '0;
        it.rdata   = '0;
        it.lat     = (we || !it.exp_mem) ? 3 : READ_LAT + 2;
        it.start   = cyc;
        if (it.exp_mem && we) begin
            for (int unsigned i = 0; i < n; i++) begin
                it.be[(ea % 4) + i] = 1'b1;
                ref_mem[ea + i]     = wd[8*i +: 8];
            end
            for (int unsigned j = 0; j < 4; j++) it.wdata[8*j +: 8] = wd[8*(j % n) +: 8];
        end else if (it.exp_mem) begin
            it.be = 4'hF;
            v     = '0;
            for (int unsigned i = 0; i < n; i++) v[8*i +: 8] = ref_mem[ea + i];
            if (sgn && v[8*n-1]) for (int unsigned k = 8*n; k < 32; k++) v[k] = 1'b1;
            it.rdata = v;
        end
        q.push_back(it);
    endtask

    task automatic pulse_reset();
        @(posedge clk); #2 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
    endtask

    task automatic run(input bit pl, input bit we, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wd);
        bit got;
        @(posedge clk); #1;
        if (pl) begin
            bus.l_req = 1'b1; bus.l_we = we; bus.l_addr = addr; bus.l_wdata = wd;
        end else begin
            bus.c_req = 1'b1; bus.c_we = we; bus.c_funct3 = f3; bus.c_addr = addr; bus.c_wdata = wd;
        end
        push_expect(pl, we, f3, addr, wd);
        got = 1'b0;
        for (int t = 0; t < 40 && !got; t++) begin
            @(negedge clk);
            got = pl ? bus.l_done : bus.c_done;
        end
        @(posedge clk); #1;
        bus.c_req = 1'b0;
        bus.l_req = 1'b0;
        if (!got) begin
            checks++; failures++;
            $display("FAIL done_timeout: port_l=%0d addr=%h got no done, expected done", pl, addr);
            q.delete();
            mem_seen = 0;
            pulse_reset();
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish, expected finish");
        $fatal(1);
    end

    initial begin
        logic [2:0] rd_f3 [0:4];
        logic [2:0] wr_f3 [0:2];
        rd_f3 = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        wr_f3 = '{3'b000, 3'b001, 3'b010};
        bus.c_req = 1'b0; bus.c_we = 1'b0; bus.c_funct3 = '0; bus.c_addr = '0; bus.c_wdata = '0;
        bus.l_req = 1'b0; bus.l_we = 1'b0; bus.l_addr = '0; bus.l_wdata = '0;
        fork
            begin : stimulus
                bit exp_l, got;
                repeat (3) @(posedge clk);
                @(negedge clk);
                chk("rst_busy",    32'(bus.busy),   32'h0);
                chk("rst_mem_en",  32'(bus.mem_en), 32'h0);
                chk("rst_mem_be",  32'(bus.mem_be), 32'h0);
                chk("rst_c_done",  32'(bus.c_done), 32'h0);
                chk("rst_l_done",  32'(bus.l_done), 32'h0);
                chk("rst_c_rdata", bus.c_rdata,     32'h0);
                @(posedge clk); #1 reset = 1'b0;

                // both ports held from reset: expect C, L, C, L
                @(posedge clk); #1;
                bus.c_req = 1'b1; bus.c_we = 1'b0; bus.c_funct3 = 3'b010; bus.c_addr = 32'h100;
                bus.l_req = 1'b1; bus.l_we = 1'b0; bus.l_addr = 32'h104;
                exp_l = 1'b0;
                for (int k = 0; k < 4; k++) begin
                    got = 1'b0;
                    for (int t = 0; t < 20 && !got; t++) begin
                        @(negedge clk);
                        got = bus.c_done || bus.l_done;
                    end
                    if (!got) begin
                        checks++; failures++;
                        $display("FAIL rr_timeout: grant %0d got no done, expected done", k);
                    end else begin
                        chk("rr_order",  32'(bus.l_done), 32'(exp_l));
                        chk("rr_single", 32'(bus.c_done && bus.l_done), 32'h0);
                    end
                    exp_l = !exp_l;
                end
                @(posedge clk); #1;
                bus.c_req = 1'b0; bus.l_req = 1'b0;
                pulse_reset();
                directed = 1'b0;

                run(1'b1, 1'b1, 3'b010, 32'h100, 32'h8000_80F0);
                run(1'b0, 1'b0, 3'b000, 32'h100, 32'h0);
                run(1'b0, 1'b0, 3'b100, 32'h101, 32'h0);
                run(1'b0, 1'b1, 3'b000, 32'h203, 32'h0000_00AB);
                run(1'b0, 1'b0, 3'b010, 32'h102, 32'h0);
                run(1'b0, 1'b0, 3'b011, 32'h100, 32'h0);
                run(1'b0, 1'b0, 3'b010, 32'h200, 32'h0);

                // reset during WAIT
                directed = 1'b1;
                @(posedge clk); #1;
                bus.c_req = 1'b1; bus.c_we = 1'b0; bus.c_funct3 = 3'b010; bus.c_addr = 32'h100;
                @(posedge clk); @(posedge clk); #2;
                chk("wait_busy", 32'(bus.busy), 32'h1);
                reset = 1'b1;
                #1;
                chk("arst_mem_en", 32'(bus.mem_en), 32'h0);
                chk("arst_busy",   32'(bus.busy),   32'h0);
                chk("arst_c_done", 32'(bus.c_done), 32'h0);
                @(posedge clk); #1 bus.c_req = 1'b0;
                @(negedge clk);
                chk("arst_no_done", 32'(bus.c_done), 32'h0);
                @(posedge clk); #1 reset = 1'b0;
                mem_seen = 0;
                directed = 1'b0;
                run(1'b0, 1'b0, 3'b010, 32'h100, 32'h0);

                for (int i = 0; i < 60; i++) begin
                    bit          pl, we;
                    int unsigned sel;
                    logic [2:0]  f3;
                    pl  = ($urandom_range(0, 2) == 0);
                    we  = 1'($urandom_range(0, 1));
                    sel = $urandom_range(0, 9);
                    f3  = we ? wr_f3[sel % 3] : rd_f3[sel % 5];
                    if (sel == 9 && !pl) f3 = 3'b110;
                    run(pl, we, f3, 32'h100 + $urandom_range(0, 63), $urandom);
                end
                repeat (3) @(posedge clk);
                chk("queue_empty", 32'(q.size()), 32'h0);
            end
            begin : monitor
                forever begin
                    @(negedge clk);
                    if (!directed) begin
                        if (bus.mem_en) begin
                            if (q.size() == 0) begin
                                checks++; failures++;
                                $display("FAIL mem_en_unexpected: got mem_en=1 with no access pending, expected 0");
                            end else begin
                                mem_seen++;
                                chk("mem_we",   32'(bus.mem_we), 32'(q[0].we));
                                chk("mem_addr", bus.mem_addr,    q[0].addr);
                                chk("mem_be",   32'(bus.mem_be), 32'(q[0].be));
                                if (q[0].we) chk("mem_wdata", bus.mem_wdata, q[0].wdata);
                            end
                        end
                        if (bus.c_done || bus.l_done) begin
                            if (q.size() == 0) begin
                                checks++; failures++;
                                $display("FAIL done_unexpected: got done with no access pending, expected none");
                            end else begin
                                item_t it;
                                it = q.pop_front();
                                chk("done_port",    32'(bus.l_done), 32'(it.port_l));
                                chk("done_single",  32'(bus.c_done && bus.l_done), 32'h0);
                                chk("latency",      cyc - it.start + 1, it.lat);
                                chk("mem_en_count", mem_seen, 32'(it.exp_mem));
                                if (!it.port_l) chk("c_err", 32'(bus.c_err), 32'(it.err));
                                if (!it.we && it.exp_mem) begin
                                    if (it.port_l) chk("l_rdata", bus.l_rdata, it.rdata);
                                    else           chk("c_rdata", bus.c_rdata, it.rdata);
                                end
                                mem_seen = 0;
                            end
                        end
                    end
                end
            end
        join_any
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
